// File: rtl/lcd_lab3_pkg.sv
// Shared constants for the lcd_lab3 HD44780 controller: FSM states, LCD commands,
// ASCII codes and the per-choice line labels.
package lcd_lab3_pkg;

   localparam logic [2:0] ST_POWERUP = 3'd0;
   localparam logic [2:0] ST_INIT    = 3'd1;
   localparam logic [2:0] ST_L1_ADDR = 3'd2;
   localparam logic [2:0] ST_L1_CHAR = 3'd3;
   localparam logic [2:0] ST_L2_ADDR = 3'd4;
   localparam logic [2:0] ST_L2_CHAR = 3'd5;

   localparam logic [7:0] CMD_FUNC  = 8'h38;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_L1    = 8'h80;
   localparam logic [7:0] CMD_L2    = 8'hC0;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   localparam logic [15:0] CH_OUT   = 16'h0000;
   localparam logic [15:0] CH_IN    = 16'h0001;
   localparam logic [15:0] CH_AB    = 16'h0002;
   localparam logic [15:0] CH_BLANK = 16'hFFFF;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC;
         2'd1:    return CMD_DISP;
         2'd2:    return CMD_CLEAR;
         default: return CMD_ENTRY;
      endcase
   endfunction

   // Label occupies columns 0-3 of each line.
   function automatic logic [7:0] label_char(input logic [15:0] choice, input logic line,
                                             input logic [1:0] col);
      logic [31:0] s;
      s = "    ";
      case (choice)
         CH_OUT:   if (!line) s = "OUT:";
         CH_IN:    if (!line) s = "IN: ";
         CH_AB:    s = line ? "B:  " : "A:  ";
         CH_BLANK: s = "    ";
         default:  if (!line) s = "CMD?";
      endcase
      case (col)
         2'd0:    return s[31:24];
         2'd1:    return s[23:16];
         2'd2:    return s[15:8];
         default: return s[7:0];
      endcase
   endfunction

   function automatic logic show_digits(input logic [15:0] choice, input logic line);
      case (choice)
         CH_OUT, CH_IN: return !line;
         CH_AB:         return 1'b1;
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lcd_lab3_bcd.sv
// Combinational double-dabble: 13-bit binary to four BCD digits (thousands 0..8).
module lcd_lab3_bcd (
   input  logic [12:0] bin_i,
   output logic [3:0]  thou_o,
   output logic [3:0]  hund_o,
   output logic [3:0]  tens_o,
   output logic [3:0]  ones_o
);

   logic [28:0] sh;

   always_comb begin
      sh = {16'd0, bin_i};
      for (int i = 0; i < 13; i++) begin
         for (int d = 0; d < 4; d++) begin
            if (sh[13+4*d +: 4] >= 4'd5) sh[13+4*d +: 4] = sh[13+4*d +: 4] + 4'd3;
         end
         sh = {sh[27:0], 1'b0};
      end
   end

   assign thou_o = sh[28:25];
   assign hund_o = sh[24:21];
   assign tens_o = sh[20:17];
   assign ones_o = sh[16:13];

endmodule

// File: rtl/lcd_lab3.sv
// HD44780 16x2 write-only controller: power-up wait, init commands, then endless
// refresh of both lines with labels and 4-digit decimal values chosen by 'choice'.
module lcd_lab3
   import lcd_lab3_pkg::*;
#(
   parameter int POWERUP_CYC = 750_000,
   parameter int BYTE_CYC    = 2_500,
   parameter int CLEAR_CYC   = 100_000,
   parameter int EN_SETUP    = 4,
   parameter int EN_HIGH     = 16
) (
   input  logic        clock_50,
   input  logic        reset,
   input  logic [15:0] choice,
   input  logic [12:0] value_1,
   input  logic [12:0] value_2,
   output logic        ready,
   output logic        lcd_on,
   output logic        lcd_blon,
   output logic        lcd_rw,
   output logic        lcd_en,
   output logic        lcd_rs,
   inout  wire  [7:0]  lcd_data
);

   localparam int TMAX_A = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
   localparam int TMAX   = (TMAX_A > BYTE_CYC) ? TMAX_A : BYTE_CYC;
   localparam int TW     = $clog2(TMAX + 1);

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, period_end;
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    data_q, data_d;
   logic          rs_q, rs_d, en_q, en_d, ready_q, ready_d;

   logic [15:0]   bcd1, bcd2, dsel;
   logic          nxt_line;
   logic [3:0]    nxt_col, digit;
   logic [7:0]    char_nxt;

   lcd_lab3_bcd u_bcd1 (
      .bin_i (value_1),
      .thou_o(bcd1[15:12]),
      .hund_o(bcd1[11:8]),
      .tens_o(bcd1[7:4]),
      .ones_o(bcd1[3:0])
   );

   lcd_lab3_bcd u_bcd2 (
      .bin_i (value_2),
      .thou_o(bcd2[15:12]),
      .hund_o(bcd2[11:8]),
      .tens_o(bcd2[7:4]),
      .ones_o(bcd2[3:0])
   );

   // Position of the character that would load next, used only in address/char states.
   always_comb begin
      nxt_line = (state_q == ST_L2_ADDR) || (state_q == ST_L2_CHAR);
      nxt_col  = ((state_q == ST_L1_CHAR) || (state_q == ST_L2_CHAR)) ? idx_q + 4'd1 : 4'd0;
      dsel     = nxt_line ? bcd2 : bcd1;
   end

   always_comb begin
      char_nxt = ASCII_SPACE;
      case (nxt_col[1:0])
         2'd0:    digit = dsel[15:12];
         2'd1:    digit = dsel[11:8];
         2'd2:    digit = dsel[7:4];
         default: digit = dsel[3:0];
      endcase
      if (nxt_col < 4'd4) char_nxt = label_char(choice, nxt_line, nxt_col[1:0]);
      else if (nxt_col >= 4'd12 && show_digits(choice, nxt_line))
         char_nxt = ASCII_ZERO + {4'd0, digit};
   end

   assign period_end = (!rs_q && data_q == CMD_CLEAR) ? TW'(CLEAR_CYC - 1) : TW'(BYTE_CYC - 1);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      idx_d   = idx_q;
      data_d  = data_q;
      rs_d    = rs_q;
      ready_d = ready_q;
      if (state_q == ST_POWERUP) begin
         if (timer_q == TW'(POWERUP_CYC - 1)) begin
            state_d = ST_INIT;
            timer_d = '0;
            idx_d   = 4'd0;
            data_d  = init_cmd(2'd0);
            rs_d    = 1'b0;
         end
      end else if (timer_q == period_end) begin
         timer_d = '0;
         case (state_q)
            ST_INIT: begin
               rs_d = 1'b0;
               if (idx_q == 4'd3) begin
                  state_d = ST_L1_ADDR;
                  data_d  = CMD_L1;
                  ready_d = 1'b1;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  data_d = init_cmd(idx_q[1:0] + 2'd1);
               end
            end
            ST_L1_ADDR, ST_L2_ADDR: begin
               state_d = (state_q == ST_L1_ADDR) ? ST_L1_CHAR : ST_L2_CHAR;
               idx_d   = 4'd0;
               data_d  = char_nxt;
               rs_d    = 1'b1;
            end
            ST_L1_CHAR, ST_L2_CHAR: begin
               if (idx_q == 4'd15) begin
                  state_d = (state_q == ST_L1_CHAR) ? ST_L2_ADDR : ST_L1_ADDR;
                  data_d  = (state_q == ST_L1_CHAR) ? CMD_L2 : CMD_L1;
                  rs_d    = 1'b0;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  data_d = char_nxt;
                  rs_d   = 1'b1;
               end
            end
            default: begin
               state_d = ST_POWERUP;
               timer_d = '0;
            end
         endcase
      end
      // EN is registered from the next timer value so it is aligned with t in the byte period.
      en_d = (state_d != ST_POWERUP) && (timer_d >= TW'(EN_SETUP)) &&
             (timer_d < TW'(EN_SETUP + EN_HIGH));
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         state_q <= ST_POWERUP;
         timer_q <= '0;
         idx_q   <= 4'd0;
         data_q  <= 8'h00;
         rs_q    <= 1'b0;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         en_q    <= en_d;
         ready_q <= ready_d;
      end
   end

   assign lcd_en   = en_q;
   assign lcd_rs   = rs_q;
   assign lcd_data = data_q;
   assign ready    = ready_q;
   assign lcd_on   = 1'b1;
   assign lcd_blon = 1'b1;
   assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_lab3.sv
// Randomized bench for lcd_lab3: captures every EN pulse and compares the byte stream
// against a line-text model built from the display rules.
module tb_lcd_lab3;

   localparam int PU = 20;
   localparam int BC = 40;
   localparam int CC = 80;
   localparam int ES = 4;
   localparam int EH = 8;

   logic        clock_50 = 1'b0;
   logic        reset    = 1'b1;
   logic [15:0] choice   = 16'h0002;
   logic [12:0] value_1  = 13'd42;
   logic [12:0] value_2  = 13'd8191;
   logic        ready, lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs;
   wire  [7:0]  lcd_data;

   logic [12:0] bcd_in = 13'd0;
   logic [3:0]  b_th, b_hu, b_te, b_on;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int last_cyc = 0;
   int hi_w = 0;
   logic en_prev = 1'b0;

   typedef struct {
      logic       rs;
      logic [7:0] dat;
      int         cyc;
      logic       rdy;
   } ev_t;
   ev_t evq[$];

   lcd_lab3 #(
      .POWERUP_CYC(PU), .BYTE_CYC(BC), .CLEAR_CYC(CC), .EN_SETUP(ES), .EN_HIGH(EH)
   ) dut (
      .clock_50(clock_50), .reset(reset), .choice(choice), .value_1(value_1),
      .value_2(value_2), .ready(ready), .lcd_on(lcd_on), .lcd_blon(lcd_blon),
      .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_data(lcd_data)
   );

   lcd_lab3_bcd u_bcd (
      .bin_i(bcd_in), .thou_o(b_th), .hund_o(b_hu), .tens_o(b_te), .ones_o(b_on)
   );

   always #10 clock_50 = ~clock_50;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic finish_up();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   endtask

   // Record each EN rising edge and check the width of each completed pulse.
   always @(negedge clock_50) begin
      cyc++;
      if (lcd_en === 1'b1 && en_prev !== 1'b1) begin
         evq.push_back('{lcd_rs, lcd_data, cyc, ready});
         hi_w = 1;
      end else if (lcd_en === 1'b1) begin
         hi_w++;
      end else if (en_prev === 1'b1 && !reset) begin
         chk("en_width", hi_w, EH);
      end
      en_prev = lcd_en;
   end

   task automatic get_ev(output ev_t e, output int gap);
      int w = 0;
      while (evq.size() == 0) begin
         @(negedge clock_50);
         w++;
         if (w > 3000) begin
            chk("byte_timeout", 0, 1);
            finish_up();
         end
      end
      e = evq.pop_front();
      gap = e.cyc - last_cyc;
      last_cyc = e.cyc;
   endtask

   function automatic logic [7:0] exp_init(input int i);
      case (i)
         0:       return 8'h38;
         1:       return 8'h0C;
         2:       return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   function automatic logic [7:0] exp_char(input logic [15:0] ch, input logic [12:0] v1,
                                           input logic [12:0] v2, input int line, input int col);
      string lbl;
      bit    dig;
      int    v, d;
      lbl = "    ";
      dig = 1'b0;
      if (ch == 16'h0000 && line == 0) begin lbl = "OUT:"; dig = 1'b1; end
      else if (ch == 16'h0001 && line == 0) begin lbl = "IN: "; dig = 1'b1; end
      else if (ch == 16'h0002) begin
         if (line == 0) lbl = "A:  ";
         else lbl = "B:  ";
         dig = 1'b1;
      end else if (ch != 16'hFFFF && ch > 16'h0002 && line == 0) lbl = "CMD?";
      if (col < 4) return lbl.getc(col);
      if (col < 12 || !dig) return 8'h20;
      v = (line == 0) ? int'(v1) : int'(v2);
      case (col)
         12:      d = v / 1000;
         13:      d = (v / 100) % 10;
         14:      d = (v / 10) % 10;
         default: d = v % 10;
      endcase
      return 8'(48 + d);
   endfunction

   task automatic check_init(input int rel);
      ev_t e;
      int  gap;
      for (int i = 0; i < 4; i++) begin
         get_ev(e, gap);
         if (i == 0) chk("powerup_gap", (e.cyc - rel >= PU) && (e.cyc - rel <= PU + ES + 3), 1);
         else chk($sformatf("init_gap%0d", i), gap, (i == 3) ? CC : BC);
         chk($sformatf("init_rs%0d", i), e.rs, 0);
         chk($sformatf("init_cmd%0d", i), e.dat, exp_init(i));
         chk($sformatf("init_ready%0d", i), e.rdy, 0);
      end
   endtask

   // One full refresh pass; optionally changes value_1 after byte 'chg_at'.
   task automatic check_pass(input logic [15:0] ch, input logic [12:0] v1, input logic [12:0] v2,
                             input int chg_at, input logic [12:0] nv1);
      ev_t e;
      int  gap, line, pos;
      for (int b = 0; b < 34; b++) begin
         get_ev(e, gap);
         line = (b >= 17) ? 1 : 0;
         pos  = b % 17;
         chk("byte_gap", gap, BC);
         if (pos == 0) begin
            chk($sformatf("addr_rs L%0d", line + 1), e.rs, 0);
            chk($sformatf("addr L%0d", line + 1), e.dat, (line == 1) ? 8'hC0 : 8'h80);
            chk("ready", e.rdy, 1);
         end else begin
            chk($sformatf("char_rs L%0d c%0d", line + 1, pos - 1), e.rs, 1);
            chk($sformatf("char L%0d c%0d ch%0h", line + 1, pos - 1, ch), e.dat,
                exp_char(ch, v1, v2, line, pos - 1));
         end
         if (b == chg_at) value_1 = nv1;
      end
   endtask

   initial begin
      int rel, v, w, r;
      logic [15:0] exp_b;
      logic [12:0] bv [4];
      logic [15:0] bx [4];
      bv = '{13'd0, 13'd8191, 13'd1000, 13'd9};
      bx = '{16'h0000, 16'h8191, 16'h1000, 16'h0009};

      for (int i = 0; i < 4; i++) begin
         bcd_in = bv[i];
         #1;
         chk($sformatf("bcd %0d", bv[i]), {b_th, b_hu, b_te, b_on}, bx[i]);
      end
      for (int i = 0; i < 8; i++) begin
         v = $urandom_range(0, 8191);
         bcd_in = 13'(v);
         exp_b = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
         #1;
         chk($sformatf("bcd %0d", v), {b_th, b_hu, b_te, b_on}, exp_b);
      end

      repeat (3) @(negedge clock_50);
      chk("rst_en", lcd_en, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_data", lcd_data, 8'h00);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_on", lcd_on, 1);
      chk("rst_blon", lcd_blon, 1);
      chk("rst_ready", ready, 0);

      reset = 1'b0;
      rel = cyc;
      check_init(rel);
      check_pass(16'h0002, 13'd42, 13'd8191, -1, 13'd0);

      choice = 16'hFFFF;
      check_pass(16'hFFFF, 13'd42, 13'd8191, -1, 13'd0);

      choice = 16'h0000;
      value_1 = 13'd0;
      check_pass(16'h0000, 13'd0, 13'd8191, 25, 13'd1234);
      check_pass(16'h0000, 13'd1234, 13'd8191, -1, 13'd0);

      for (int i = 0; i < 6; i++) begin
         r = $urandom_range(0, 4);
         case (r)
            0:       choice = 16'h0000;
            1:       choice = 16'h0001;
            2:       choice = 16'h0002;
            3:       choice = 16'hFFFF;
            default: choice = 16'($urandom_range(3, 16'hFFFE));
         endcase
         value_1 = 13'($urandom_range(0, 8191));
         value_2 = 13'($urandom_range(0, 8191));
         check_pass(choice, value_1, value_2, -1, 13'd0);
      end

      w = 0;
      while (lcd_en !== 1'b1) begin
         @(negedge clock_50);
         w++;
         if (w > 200) begin
            chk("en_wait_timeout", 0, 1);
            finish_up();
         end
      end
      reset = 1'b1;
      @(posedge clock_50);
      #1;
      chk("abort_en", lcd_en, 0);
      chk("abort_data", lcd_data, 8'h00);
      chk("abort_rs", lcd_rs, 0);
      chk("abort_ready", ready, 0);
      repeat (2) @(negedge clock_50);
      evq.delete();
      reset = 1'b0;
      rel = cyc;
      check_init(rel);
      choice = 16'h0001;
      value_1 = 13'd507;
      check_pass(16'h0001, 13'd507, value_2, -1, 13'd0);

      finish_up();
   end

endmodule
